// File: rtl/bsg_chip_link_loopback_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bsg_chip_link_loopback_bist
// Description : Per-channel link loopback / BIST block. Each of the
//               num_channels_p ready/valid channels is selected as off,
//               two-entry buffered loopback, or counting-pattern
//               generator/checker with saturating pass/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_chip_link_loopback_bist #(
    parameter int width_p        = 64,
    parameter int num_channels_p = 4,
    parameter int cnt_width_p    = 16
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_channels_p-1:0][1:0]             mode_i,
    input  logic [num_channels_p-1:0]                  clear_i,
    input  logic [num_channels_p-1:0]                  in_v_i,
    input  logic [num_channels_p-1:0][width_p-1:0]     in_data_i,
    output logic [num_channels_p-1:0]                  in_ready_o,
    output logic [num_channels_p-1:0]                  out_v_o,
    output logic [num_channels_p-1:0][width_p-1:0]     out_data_o,
    input  logic [num_channels_p-1:0]                  out_ready_i,
    output logic [num_channels_p-1:0][cnt_width_p-1:0] err_cnt_o,
    output logic [num_channels_p-1:0][cnt_width_p-1:0] pass_cnt_o,
    output logic [num_channels_p-1:0]                  err_o
);

    localparam logic [1:0]             C_MODE_LOOP = 2'b01;
    localparam logic [1:0]             C_MODE_BIST = 2'b10;
    localparam logic [width_p-1:0]     C_ONE_W     = width_p'(1);
    localparam logic [cnt_width_p-1:0] C_ONE_C     = cnt_width_p'(1);
    localparam logic [cnt_width_p-1:0] C_CNT_MAX   = '1;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        logic [1:0]             mode_q;
        logic                   rd_ptr_q, rd_ptr_d;
        logic                   wr_ptr_q, wr_ptr_d;
        logic [1:0]             occ_q, occ_d;
        logic [width_p-1:0]     mem_q [2];
        logic [width_p-1:0]     gen_q, gen_d;
        logic [width_p-1:0]     chk_q, chk_d;
        logic [cnt_width_p-1:0] err_cnt_q, err_cnt_d;
        logic [cnt_width_p-1:0] pass_cnt_q, pass_cnt_d;
        logic                   err_q, err_d;
        logic                   mode_chg, is_loop, is_bist;
        logic                   ready, valid, in_hs, out_hs;
        logic [width_p-1:0]     data;

        // A pending mode change blocks both handshakes for this cycle so the
        // flush below never races with an accepted or delivered word.
        assign mode_chg = (mode_i[c] != mode_q);
        assign is_loop  = (mode_q == C_MODE_LOOP);
        assign is_bist  = (mode_q == C_MODE_BIST);

        // Link-side handshake signals and data, all decoded from the registered mode.
        always_comb begin
            ready = 1'b0;
            valid = 1'b0;
            data  = '0;
            if (is_loop) begin
                data = mem_q[rd_ptr_q];
                if (!mode_chg) begin
                    ready = (occ_q != 2'd2);
                    valid = (occ_q != 2'd0);
                end
            end else if (is_bist) begin
                data = gen_q;
                if (!mode_chg) begin
                    ready = 1'b1;
                    valid = 1'b1;
                end
            end
        end

        assign in_hs  = in_v_i[c] & ready;
        assign out_hs = valid & out_ready_i[c];

        // Next state for the FIFO pointers and pattern counters.
        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            occ_d    = occ_q;
            gen_d    = gen_q;
            chk_d    = chk_q;
            if (mode_chg) begin
                rd_ptr_d = 1'b0;
                wr_ptr_d = 1'b0;
                occ_d    = 2'd0;
                gen_d    = '0;
                chk_d    = '0;
            end else if (is_loop) begin
                if (in_hs)  wr_ptr_d = ~wr_ptr_q;
                if (out_hs) rd_ptr_d = ~rd_ptr_q;
                case ({in_hs, out_hs})
                    2'b10:   occ_d = occ_q + 2'd1;
                    2'b01:   occ_d = occ_q - 2'd1;
                    default: occ_d = occ_q;
                endcase
            end else if (is_bist) begin
                if (out_hs) gen_d = gen_q + C_ONE_W;
                if (in_hs)  chk_d = chk_q + C_ONE_W;
            end
        end

        // Next state for the saturating bring-up counters; clear beats a same-cycle event.
        always_comb begin
            err_cnt_d  = err_cnt_q;
            pass_cnt_d = pass_cnt_q;
            err_d      = err_q;
            if (clear_i[c]) begin
                err_cnt_d  = '0;
                pass_cnt_d = '0;
                err_d      = 1'b0;
            end else if (is_bist && in_hs) begin
                if (in_data_i[c] == chk_q) begin
                    if (pass_cnt_q != C_CNT_MAX) pass_cnt_d = pass_cnt_q + C_ONE_C;
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != C_CNT_MAX) err_cnt_d = err_cnt_q + C_ONE_C;
                end
            end
        end

        // State registers, including the two FIFO storage words.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                mode_q     <= 2'b00;
                rd_ptr_q   <= 1'b0;
                wr_ptr_q   <= 1'b0;
                occ_q      <= 2'd0;
                mem_q[0]   <= '0;
                mem_q[1]   <= '0;
                gen_q      <= '0;
                chk_q      <= '0;
                err_cnt_q  <= '0;
                pass_cnt_q <= '0;
                err_q      <= 1'b0;
            end else begin
                mode_q     <= mode_i[c];
                rd_ptr_q   <= rd_ptr_d;
                wr_ptr_q   <= wr_ptr_d;
                occ_q      <= occ_d;
                gen_q      <= gen_d;
                chk_q      <= chk_d;
                err_cnt_q  <= err_cnt_d;
                pass_cnt_q <= pass_cnt_d;
                err_q      <= err_d;
                if (is_loop && in_hs) mem_q[wr_ptr_q] <= in_data_i[c];
            end
        end

        assign in_ready_o[c] = ready;
        assign out_v_o[c]    = valid;
        assign out_data_o[c] = data;
        assign err_cnt_o[c]  = err_cnt_q;
        assign pass_cnt_o[c] = pass_cnt_q;
        assign err_o[c]      = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_chip_link_loopback_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bsg_chip_link_loopback_bist
// Description : Self-checking bench: directed scenarios plus random traffic
//               compared against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_chip_link_loopback_bist;
    localparam int W    = 64;
    localparam int N    = 4;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [N-1:0][1:0]   mode_i;
    logic [N-1:0]        clear_i, in_v_i, out_ready_i;
    logic [N-1:0][W-1:0] in_data_i;
    logic [N-1:0]        in_ready_o, out_v_o, err_o;
    logic [N-1:0][W-1:0] out_data_o;
    logic [N-1:0][CW-1:0] err_cnt_o, pass_cnt_o;

    // Narrow single-channel instance for counter saturation.
    logic [0:0][1:0] s_mode;
    logic [0:0]      s_clear, s_in_v, s_out_ready, s_in_ready, s_out_v, s_err;
    logic [0:0][7:0] s_in_data, s_out_data;
    logic [0:0][3:0] s_err_cnt, s_pass_cnt;

    bsg_chip_link_loopback_bist #(.width_p(W), .num_channels_p(N), .cnt_width_p(CW)) dut (
        .clk_i(clk), .reset_i(rst), .mode_i(mode_i), .clear_i(clear_i),
        .in_v_i(in_v_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_v_o(out_v_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .err_cnt_o(err_cnt_o), .pass_cnt_o(pass_cnt_o), .err_o(err_o));

    bsg_chip_link_loopback_bist #(.width_p(8), .num_channels_p(1), .cnt_width_p(4)) dut_s (
        .clk_i(clk), .reset_i(rst), .mode_i(s_mode), .clear_i(s_clear),
        .in_v_i(s_in_v), .in_data_i(s_in_data), .in_ready_o(s_in_ready),
        .out_v_o(s_out_v), .out_data_o(s_out_data), .out_ready_i(s_out_ready),
        .err_cnt_o(s_err_cnt), .pass_cnt_o(s_pass_cnt), .err_o(s_err));

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-channel word queue, pattern counts, event tallies.
    logic [1:0]   m_mode [N];
    logic [W-1:0] m_q    [N][$];
    logic [W-1:0] m_gen  [N];
    logic [W-1:0] m_chk  [N];
    int           m_err  [N];
    int           m_pass [N];
    bit           m_sticky [N];
    bit           e_rdy [N];
    bit           e_v   [N];
    bit           e_dchk[N];
    logic [W-1:0] e_data[N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 2'b00; m_q[c].delete(); m_gen[c] = '0; m_chk[c] = '0;
            m_err[c] = 0; m_pass[c] = 0; m_sticky[c] = 1'b0;
        end
    endtask

    task automatic model_expect();
        for (int c = 0; c < N; c++) begin
            bit chg;
            chg = (mode_i[c] != m_mode[c]);
            e_rdy[c] = 1'b0; e_v[c] = 1'b0; e_data[c] = '0; e_dchk[c] = 1'b1;
            if (m_mode[c] == 2'b01) begin
                e_rdy[c]  = !chg && (m_q[c].size() < 2);
                e_v[c]    = !chg && (m_q[c].size() > 0);
                e_data[c] = (m_q[c].size() > 0) ? m_q[c][0] : '0;
                e_dchk[c] = e_v[c];
            end else if (m_mode[c] == 2'b10) begin
                e_rdy[c]  = !chg;
                e_v[c]    = !chg;
                e_data[c] = m_gen[c];
                e_dchk[c] = e_v[c];
            end
        end
    endtask

    task automatic model_commit();
        for (int c = 0; c < N; c++) begin
            bit chg, hin, hout, match;
            chg   = (mode_i[c] != m_mode[c]);
            hin   = in_v_i[c] && e_rdy[c];
            hout  = e_v[c] && out_ready_i[c];
            match = (in_data_i[c] == m_chk[c]);
            if (chg) begin
                m_q[c].delete(); m_gen[c] = '0; m_chk[c] = '0;
            end else if (m_mode[c] == 2'b01) begin
                if (hout) void'(m_q[c].pop_front());
                if (hin)  m_q[c].push_back(in_data_i[c]);
            end else if (m_mode[c] == 2'b10) begin
                if (hout) m_gen[c] = m_gen[c] + 1;
                if (hin)  m_chk[c] = m_chk[c] + 1;
            end
            if (clear_i[c]) begin
                m_err[c] = 0; m_pass[c] = 0; m_sticky[c] = 1'b0;
            end else if (m_mode[c] == 2'b10 && hin) begin
                if (match) m_pass[c] = (m_pass[c] < CMAX) ? m_pass[c] + 1 : CMAX;
                else begin
                    m_err[c] = (m_err[c] < CMAX) ? m_err[c] + 1 : CMAX;
                    m_sticky[c] = 1'b1;
                end
            end
            m_mode[c] = mode_i[c];
        end
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_sample();
        @(negedge clk);
        model_expect();
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            checks++;
            if ({in_ready_o[c], out_v_o[c], err_o[c], out_data_o[c], err_cnt_o[c], pass_cnt_o[c]} !== '0) begin
                errors++;
                $display("FAIL reset_state ch%0d got rdy=%b v=%b err=%b data=%h ec=%h pc=%h want all zero",
                         c, in_ready_o[c], out_v_o[c], err_o[c], out_data_o[c], err_cnt_o[c], pass_cnt_o[c]);
            end
        end
        checks++;
        if ({s_in_ready, s_out_v, s_err, s_out_data, s_err_cnt, s_pass_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state_small got v=%b ec=%h want zero", s_out_v, s_err_cnt);
        end
        cyc_begin();
        rst = 1'b0;
        cyc_sample();
        model_commit();
    endtask

    task automatic test_reset_mid_traffic();
        logic [W-1:0] a;
        bit got;
        cyc_begin(); mode_i[0] = 2'b01; cyc_sample(); model_commit();
        for (int k = 0; k < 2; k++) begin
            cyc_begin(); out_ready_i[0] = 1'b0; in_v_i[0] = 1'b1; in_data_i[0] = {$urandom, $urandom};
            cyc_sample(); model_commit();
        end
        cyc_begin(); in_v_i[0] = 1'b0; cyc_sample();
        checks++;
        if ({in_ready_o[0], out_v_o[0]} !== 2'b01) begin
            errors++;
            $display("FAIL full_before_reset got rdy=%b v=%b want rdy=0 v=1", in_ready_o[0], out_v_o[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready_o[0], out_v_o[0], out_data_o[0]} !== '0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b v=%b data=%h want 0", in_ready_o[0], out_v_o[0], out_data_o[0]);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a = {$urandom, $urandom};
        in_v_i[0] = 1'b1; in_data_i[0] = a; out_ready_i[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            if (k > 0) cyc_begin();
            cyc_sample();
            checks++;
            if (in_ready_o[0] !== e_rdy[0]) begin
                errors++;
                $display("FAIL post_reset_ready got %b want %b", in_ready_o[0], e_rdy[0]);
            end
            got = e_rdy[0];
            model_commit();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL post_reset_accept got no accept want accept within 5 cycles");
        end
        cyc_begin(); in_v_i[0] = 1'b0; cyc_sample();
        checks++;
        if ({out_v_o[0], out_data_o[0]} !== {1'b1, a}) begin
            errors++;
            $display("FAIL post_reset_first_word got v=%b data=%h want v=1 data=%h", out_v_o[0], out_data_o[0], a);
        end
        model_commit();
    endtask

    task automatic test_loopback_throughput();
        cyc_begin(); in_v_i[0] = 1'b0; out_ready_i[0] = 1'b1; cyc_sample(); model_commit();
        for (int i = 0; i < 17; i++) begin
            cyc_begin();
            in_v_i[0] = (i < 16); in_data_i[0] = W'(i + 1);
            cyc_sample();
            checks++;
            if (i < 16 && in_ready_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL thru_ready i=%0d got %b want 1", i, in_ready_o[0]);
            end
            checks++;
            if (i == 0 && out_v_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL thru_first_empty got v=%b want 0", out_v_o[0]);
            end else if (i > 0 && {out_v_o[0], out_data_o[0]} !== {1'b1, W'(i)}) begin
                errors++;
                $display("FAIL thru_data i=%0d got v=%b data=%h want v=1 data=%h", i, out_v_o[0], out_data_o[0], i);
            end
            model_commit();
        end
        for (int j = 0; j < 3; j++) begin
            cyc_begin(); out_ready_i[0] = 1'b0; in_v_i[0] = 1'b1; in_data_i[0] = W'(32'h21 + j);
            cyc_sample();
            checks++;
            if (in_ready_o[0] !== (j < 2)) begin
                errors++;
                $display("FAIL backpressure_ready j=%0d got %b want %b", j, in_ready_o[0], (j < 2));
            end
            model_commit();
        end
        for (int j = 0; j < 3; j++) begin
            cyc_begin(); out_ready_i[0] = 1'b1; in_v_i[0] = 1'b0;
            cyc_sample();
            checks++;
            if (j < 2 && {out_v_o[0], out_data_o[0]} !== {1'b1, W'(32'h21 + j)}) begin
                errors++;
                $display("FAIL drain j=%0d got v=%b data=%h want v=1 data=%h", j, out_v_o[0], out_data_o[0], 32'h21 + j);
            end else if (j == 2 && out_v_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL drain_empty got v=%b want 0", out_v_o[0]);
            end
            model_commit();
        end
        cyc_begin(); out_ready_i[0] = 1'b0; cyc_sample(); model_commit();
    endtask

    task automatic test_bist_run(input int bad_idx, input string tag);
        cyc_begin(); mode_i[0] = 2'b00; clear_i[0] = 1'b1; cyc_sample(); model_commit();
        cyc_begin(); mode_i[0] = 2'b10; cyc_sample(); model_commit();
        for (int i = 0; i < 100; i++) begin
            cyc_begin();
            clear_i[0] = 1'b0; out_ready_i[0] = 1'b1;
            in_v_i[0] = out_v_o[0];
            in_data_i[0] = out_data_o[0] ^ ((i == bad_idx) ? W'(8) : W'(0));
            cyc_sample();
            checks++;
            if ({out_v_o[0], out_data_o[0]} !== {1'b1, W'(i)}) begin
                errors++;
                $display("FAIL %s_gen i=%0d got v=%b data=%h want v=1 data=%h", tag, i, out_v_o[0], out_data_o[0], i);
            end
            if (bad_idx >= 0 && i == 7) begin
                checks++;
                if ({err_cnt_o[0], pass_cnt_o[0], err_o[0]} !== {CW'(1), CW'(6), 1'b1}) begin
                    errors++;
                    $display("FAIL %s_resume got ec=%0d pc=%0d err=%b want ec=1 pc=6 err=1",
                             tag, err_cnt_o[0], pass_cnt_o[0], err_o[0]);
                end
            end
            model_commit();
        end
        cyc_begin(); in_v_i[0] = 1'b0; out_ready_i[0] = 1'b0; cyc_sample();
        checks++;
        if (bad_idx < 0 && {err_cnt_o[0], pass_cnt_o[0], err_o[0]} !== {CW'(0), CW'(100), 1'b0}) begin
            errors++;
            $display("FAIL %s_counts got ec=%0d pc=%0d err=%b want ec=0 pc=100 err=0",
                     tag, err_cnt_o[0], pass_cnt_o[0], err_o[0]);
        end else if (bad_idx >= 0 && {err_cnt_o[0], pass_cnt_o[0], err_o[0]} !== {CW'(1), CW'(99), 1'b1}) begin
            errors++;
            $display("FAIL %s_counts got ec=%0d pc=%0d err=%b want ec=1 pc=99 err=1",
                     tag, err_cnt_o[0], pass_cnt_o[0], err_o[0]);
        end
        model_commit();
    endtask

    task automatic test_bist_self_loop();
        test_bist_run(-1, "bist_loop");
    endtask

    task automatic test_bist_error_injection();
        test_bist_run(5, "bist_inject");
    endtask

    task automatic test_saturation_clear();
        cyc_begin(); s_mode[0] = 2'b10; s_out_ready[0] = 1'b1; cyc_sample(); model_commit();
        for (int i = 0; i < 20; i++) begin
            cyc_begin(); s_in_v[0] = 1'b1; s_in_data[0] = 8'hFF; cyc_sample(); model_commit();
        end
        cyc_begin(); s_clear[0] = 1'b1; cyc_sample();
        checks++;
        if ({s_err_cnt[0], s_pass_cnt[0], s_err[0]} !== {4'hF, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL sat_hold got ec=%h pc=%h err=%b want ec=f pc=0 err=1", s_err_cnt[0], s_pass_cnt[0], s_err[0]);
        end
        model_commit();
        cyc_begin(); s_clear[0] = 1'b0; cyc_sample();
        checks++;
        if ({s_err_cnt[0], s_err[0]} !== {4'h0, 1'b0}) begin
            errors++;
            $display("FAIL clear_wins got ec=%h err=%b want ec=0 err=0", s_err_cnt[0], s_err[0]);
        end
        model_commit();
        cyc_begin(); s_in_v[0] = 1'b0; cyc_sample();
        checks++;
        if ({s_err_cnt[0], s_err[0]} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL count_after_clear got ec=%h err=%b want ec=1 err=1", s_err_cnt[0], s_err[0]);
        end
        model_commit();
    endtask

    task automatic test_mode_switch_isolation();
        logic [W-1:0] p;
        p = {$urandom, $urandom};
        cyc_begin(); mode_i[1] = 2'b01; mode_i[2] = 2'b01; cyc_sample(); model_commit();
        for (int k = 0; k < 10; k++) begin
            cyc_begin();
            in_v_i[2] = 1'b1; in_data_i[2] = W'(32'h100 + k); out_ready_i[2] = 1'b1;
            in_v_i[1] = (k == 0); in_data_i[1] = p;
            if (k == 0) out_ready_i[1] = 1'b0;
            if (k == 3) mode_i[1] = 2'b10;
            if (k == 4) out_ready_i[1] = 1'b1;
            cyc_sample();
            checks++;
            if (in_ready_o[2] !== 1'b1 || (k > 0 && {out_v_o[2], out_data_o[2]} !== {1'b1, W'(32'h100 + k - 1)})) begin
                errors++;
                $display("FAIL iso_ch2 k=%0d got rdy=%b v=%b data=%h want rdy=1 v=1 data=%h",
                         k, in_ready_o[2], out_v_o[2], out_data_o[2], 32'h100 + k - 1);
            end
            if (k == 1 || k == 4 || k == 5) begin
                logic [W-1:0] want;
                want = (k == 1) ? p : W'(k - 4);
                checks++;
                if ({out_v_o[1], out_data_o[1]} !== {1'b1, want}) begin
                    errors++;
                    $display("FAIL iso_ch1 k=%0d got v=%b data=%h want v=1 data=%h", k, out_v_o[1], out_data_o[1], want);
                end
            end
            if (k == 3) begin
                checks++;
                if ({in_ready_o[1], out_v_o[1]} !== 2'b00) begin
                    errors++;
                    $display("FAIL iso_switch_cycle got rdy=%b v=%b want 0 0", in_ready_o[1], out_v_o[1]);
                end
            end
            model_commit();
        end
    endtask

    task automatic test_random_traffic();
        for (int n = 0; n < 400; n++) begin
            cyc_begin();
            for (int c = 0; c < N; c++) begin
                if (n == 0 || $urandom_range(0, 31) == 0) mode_i[c] = 2'($urandom_range(0, 3));
                clear_i[c]     = ($urandom_range(0, 15) == 0);
                out_ready_i[c] = 1'($urandom_range(0, 1));
                in_v_i[c]      = 1'($urandom_range(0, 1));
                if (m_mode[c] == 2'b10 && $urandom_range(0, 3) != 0) in_data_i[c] = m_chk[c];
                else in_data_i[c] = {$urandom, $urandom};
            end
            cyc_sample();
            for (int c = 0; c < N; c++) begin
                checks++;
                if ({in_ready_o[c], out_v_o[c]} !== {e_rdy[c], e_v[c]}) begin
                    errors++;
                    $display("FAIL rand_hs n=%0d ch%0d got rdy=%b v=%b want rdy=%b v=%b",
                             n, c, in_ready_o[c], out_v_o[c], e_rdy[c], e_v[c]);
                end
                checks++;
                if (e_dchk[c] && out_data_o[c] !== e_data[c]) begin
                    errors++;
                    $display("FAIL rand_data n=%0d ch%0d got %h want %h", n, c, out_data_o[c], e_data[c]);
                end
                checks++;
                if ({err_cnt_o[c], pass_cnt_o[c], err_o[c]} !== {CW'(m_err[c]), CW'(m_pass[c]), m_sticky[c]}) begin
                    errors++;
                    $display("FAIL rand_cnt n=%0d ch%0d got ec=%0d pc=%0d err=%b want ec=%0d pc=%0d err=%b",
                             n, c, err_cnt_o[c], pass_cnt_o[c], err_o[c], m_err[c], m_pass[c], m_sticky[c]);
                end
            end
            model_commit();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mode_i = '0; clear_i = '0; in_v_i = '0; in_data_i = '0; out_ready_i = '0;
        s_mode = '0; s_clear = '0; s_in_v = '0; s_in_data = '0; s_out_ready = '0;
        test_reset();
        test_reset_mid_traffic();
        test_loopback_throughput();
        test_bist_self_loop();
        test_bist_error_injection();
        test_saturation_clear();
        test_mode_switch_isolation();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bsg_chip_link_loopback_bist.md
Name: bsg_chip_link_loopback_bist

Overview:
- Parametrised successor to the core-complex fixed wire loopback.
- Sits between chip I/O or memory link endpoints and the core.
- Provides num_channels_p independent ready/valid channels, each selectable per channel as off, buffered loopback, or built-in self-test (BIST) pattern generator/checker.
- BIST mode keeps saturating error and pass counters for bring-up.

Parameters:
- width_p, 64: data width of every channel link.
- num_channels_p, 4: number of independent channels.
- cnt_width_p, 16: width of each per-channel error and pass counter.

Ports:
- clk_i  in  1  block clock
- reset_i  in  1  asynchronous, active-high reset
- mode_i  in  [num_channels_p][2]  per-channel mode: 00 off, 01 loopback, 10 BIST, 11 treated as off
- clear_i  in  [num_channels_p]  per-channel counter/sticky clear, level-sensitive
- in_v_i  in  [num_channels_p]  incoming link valid
- in_data_i  in  [num_channels_p][width_p]  incoming link data
- in_ready_o  out  [num_channels_p]  incoming link ready
- out_v_o  out  [num_channels_p]  outgoing link valid
- out_data_o  out  [num_channels_p][width_p]  outgoing link data
- out_ready_i  in  [num_channels_p]  outgoing link ready
- err_cnt_o  out  [num_channels_p][cnt_width_p]  saturating BIST mismatch count
- pass_cnt_o  out  [num_channels_p][cnt_width_p]  saturating BIST match count
- err_o  out  [num_channels_p]  sticky flag: at least one mismatch since clear

Behaviour:
- Channels are fully independent; all rules below apply per channel.
- Handshakes:
  - Input handshake = in_v_i & in_ready_o. Output handshake = out_v_o & out_ready_i.
  - out_v_o never depends combinationally on out_ready_i.
  - in_ready_o never depends combinationally on in_v_i.
- Reset (asynchronous):
  - in_ready_o=0, out_v_o=0, out_data_o=0, err_cnt_o=0, pass_cnt_o=0, err_o=0.
  - FIFO empty, generator and checker counters 0, registered mode mode_r=00.
- Mode register:
  - mode_r <= mode_i every cycle. Outputs are driven from mode_r, so a mode change takes effect one cycle after mode_i changes.
  - On any cycle where mode_i != mode_r: flush the FIFO, zero the generator and checker counters; no handshake is accepted in that cycle (in_ready_o and out_v_o forced 0).
  - err/pass counters and err_o are retained across mode changes.
  - Changing mode while out_v_o=1 is legal; the pending word is dropped.
- Off (00 or 11): in_ready_o=0, out_v_o=0, out_data_o=0.
- Loopback (01):
  - Two-entry FIFO. in_ready_o = !full; out_v_o = !empty; out_data_o = head entry.
  - Latency: a word accepted in cycle N is visible on out_data_o in cycle N+1.
  - Full throughput, 1 word/cycle, when out_ready_i is held high.
  - Simultaneous enqueue and dequeue when full is not allowed, because in_ready_o=0 when full.
  - Simultaneous enqueue and dequeue with one entry is allowed; occupancy stays 1.
  - Data order is preserved; no word is lost or duplicated.
- BIST (10):
  - Generator: out_v_o=1 continuously. out_data_o = gen_cnt zero-extended to width_p. gen_cnt increments by 1 on each output handshake and wraps modulo 2^width_p.
  - Checker: in_ready_o=1 continuously. On each input handshake:
    - Compare in_data_i to chk_cnt (zero-extended).
    - Match: pass_cnt +1. Mismatch: err_cnt +1 and err_o <= 1.
    - chk_cnt increments regardless of the result; there is no resynchronisation to received data.
  - Counters saturate at all-ones and do not wrap.
- clear_i: zeroes err_cnt, pass_cnt and err_o on the next edge. If clear and a counted event occur in the same cycle, clear wins and the event is not counted. clear_i does not affect FIFO or generator/checker state.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight data is discarded.

Test Plan:
- Reset mid-traffic: assert reset_i while a loopback FIFO holds 2 words -> out_v_o=0 and in_ready_o=0 asynchronously; after release with mode 01 held, the first accepted word is the first output word.
- Loopback throughput: mode 01, out_ready_i=1, feed 0x1..0x10 back-to-back -> identical sequence out, each 1 cycle later, no bubbles. Then hold out_ready_i=0 -> in_ready_o drops after 2 accepted words; release -> both drain in order.
- BIST self-loop: channel 0 in mode 10 with out wired to in, 100 cycles -> pass_cnt=100, err_cnt=0, err_o=0; out_data_o sequence 0,1,2,...
- BIST error injection: flip bit 3 of word 5 -> err_cnt=1, err_o=1, pass_cnt=99 after 100 words; checker continues matching word 6 onward.
- Saturation and clear: cnt_width_p=4, 20 mismatches -> err_cnt=15 held. Assert clear_i in the same cycle as a mismatch -> err_cnt=0, err_o=0.
- Mode switch isolation: channel 1 switches 01->10 with a pending word while channel 2 streams loopback -> channel 1 pending word dropped, generator restarts at 0; channel 2 data sequence unaffected.
